// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// States, opcodes and datapath mux/ALU select encodings.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH,
    JAL,
    TRAP
  } mc_state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_alu_ctrl_dec.sv
// ALU operation decode and branch-condition evaluation.
// Flags unsupported funct3 values for R/I/B-type instructions.
module mc_alu_ctrl_dec
  import riscv_mc_pkg::*;
#(
  parameter bit EXT_BRANCH = 1'b1
) (
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Negative,
  input  logic       Overflow,
  input  logic       Carry,
  output logic [2:0] ALUControl,
  output logic       taken,
  output logic       funct_illegal
);

  logic is_alu;
  logic is_br;
  logic lt;

  assign is_alu = (Op == OP_R) || (Op == OP_I);
  assign is_br  = (Op == OP_BR);
  assign lt     = Negative ^ Overflow;

  always_comb begin
    ALUControl    = ALU_ADD;
    taken         = 1'b0;
    funct_illegal = 1'b0;
    unique case (1'b1)
      is_alu: begin
        unique case (funct3)
          3'b000: ALUControl = (Op == OP_R && funct7b5)
                             ? ALU_SUB : ALU_ADD;
          3'b010: ALUControl = ALU_SLT;
          3'b110: ALUControl = ALU_OR;
          3'b111: ALUControl = ALU_AND;
          default: funct_illegal = 1'b1;
        endcase
      end
      is_br: begin
        ALUControl = ALU_SUB;
        unique case (funct3)
          3'b000: taken = Zero;
          3'b001: taken = ~Zero;
          3'b100: taken = lt;
          3'b101: taken = ~lt;
          3'b110: taken = ~Carry;
          3'b111: taken = Carry;
          default: funct_illegal = 1'b1;
        endcase
        // BEQ-only build: anything else traps
        if (!EXT_BRANCH && funct3 != 3'b000)
          funct_illegal = 1'b1;
        if (funct_illegal)
          taken = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencer for the multicycle RV32I datapath.
// Mealy terms only on MemReady (FETCH) and branch flags.
module multicycle_controller
  import riscv_mc_pkg::*;
#(
  parameter bit EXT_BRANCH    = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Negative,
  input  logic       Overflow,
  input  logic       Carry,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       Illegal
);

  mc_state_t  state;
  mc_state_t  state_n;
  logic       mem_rdy;
  logic [2:0] dec_alu;
  logic       taken;
  logic       funct_ill;
  logic       pcw;
  logic       mw;
  logic       irw;
  logic       rw;

  assign mem_rdy = MEM_HANDSHAKE ? MemReady : 1'b1;

  mc_alu_ctrl_dec #(
    .EXT_BRANCH(EXT_BRANCH)
  ) u_dec (
    .Op           (Op),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .Zero         (Zero),
    .Negative     (Negative),
    .Overflow     (Overflow),
    .Carry        (Carry),
    .ALUControl   (dec_alu),
    .taken        (taken),
    .funct_illegal(funct_ill)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    pcw        = 1'b0;
    AdrSrc     = 1'b0;
    mw         = 1'b0;
    irw        = 1'b0;
    rw         = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    ALUControl = ALU_ADD;
    Illegal    = 1'b0;
    unique case (state)
      FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        irw       = mem_rdy;
        pcw       = mem_rdy;
        if (mem_rdy) state_n = DECODE;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        unique case (1'b1)
          (Op == OP_LOAD),
          (Op == OP_STORE): state_n = MEMADR;
          (Op == OP_R):     state_n = EXECUTER;
          (Op == OP_I):     state_n = EXECUTEI;
          (Op == OP_BR):    state_n = BRANCH;
          (Op == OP_JAL):   state_n = JAL;
          default:          state_n = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_n = (Op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_rdy) state_n = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        rw        = 1'b1;
        state_n   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mw     = 1'b1;
        if (mem_rdy) state_n = FETCH;
      end
      EXECUTER: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_RD2;
        ALUControl = dec_alu;
        state_n    = funct_ill ? TRAP : ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = dec_alu;
        state_n    = funct_ill ? TRAP : ALUWB;
      end
      ALUWB: begin
        rw      = 1'b1;
        state_n = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_RD2;
        ALUControl = ALU_SUB;
        pcw        = taken;
        state_n    = funct_ill ? TRAP : FETCH;
      end
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        pcw     = 1'b1;
        state_n = ALUWB;
      end
      TRAP: Illegal = 1'b1;
      default: state_n = FETCH;
    endcase
  end

  always_comb begin
    ImmSrc = IMM_I;
    unique case (1'b1)
      (Op == OP_STORE): ImmSrc = IMM_S;
      (Op == OP_BR):    ImmSrc = IMM_B;
      (Op == OP_JAL):   ImmSrc = IMM_J;
      default:          ImmSrc = IMM_I;
    endcase
  end

  // strobes drop the instant reset asserts, before the state clears
  assign PCWrite  = pcw & reset_n;
  assign IRWrite  = irw & reset_n;
  assign RegWrite = rw  & reset_n;
  assign MemWrite = mw  & reset_n;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller.
// Two instances: full branch support and BEQ-only.
module tb_multicycle_controller;

  logic       clk;
  logic       reset_n;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero, Negative, Overflow, Carry;
  logic       MemReady;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  logic       b_PCWrite, b_AdrSrc, b_MemWrite, b_IRWrite;
  logic       b_RegWrite, b_Illegal;
  logic [1:0] b_ResultSrc, b_ALUSrcA, b_ALUSrcB, b_ImmSrc;
  logic [2:0] b_ALUControl;

  logic [16:0] obs, obs_b;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  multicycle_controller #(
    .EXT_BRANCH(1'b1), .MEM_HANDSHAKE(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .funct3(funct3),
    .funct7b5(funct7b5), .Zero(Zero), .Negative(Negative),
    .Overflow(Overflow), .Carry(Carry), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .Illegal(Illegal)
  );

  multicycle_controller #(
    .EXT_BRANCH(1'b0), .MEM_HANDSHAKE(1'b1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .Op(Op), .funct3(funct3),
    .funct7b5(funct7b5), .Zero(Zero), .Negative(Negative),
    .Overflow(Overflow), .Carry(Carry), .MemReady(MemReady),
    .PCWrite(b_PCWrite), .AdrSrc(b_AdrSrc), .MemWrite(b_MemWrite),
    .IRWrite(b_IRWrite), .ResultSrc(b_ResultSrc),
    .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .ImmSrc(b_ImmSrc),
    .RegWrite(b_RegWrite), .ALUControl(b_ALUControl),
    .Illegal(b_Illegal)
  );

  // {PCW,Adr,MW,IRW,Res[2],SrcA[2],SrcB[2],Imm[2],RW,ALU[3],Ill}
  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, RegWrite, ALUControl,
                Illegal};
  assign obs_b = {b_PCWrite, b_AdrSrc, b_MemWrite, b_IRWrite,
                  b_ResultSrc, b_ALUSrcA, b_ALUSrcB, b_ImmSrc,
                  b_RegWrite, b_ALUControl, b_Illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n  = 1'b0;
    MemReady = 1'b1;
    Op = LW; funct3 = 3'b000; funct7b5 = 1'b0;
    Zero = 1'b0; Negative = 1'b0; Overflow = 1'b0; Carry = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (obs !== 17'b0_0_0_0_10_00_10_00_0_000_0) begin
      errors++;
      $display("FAIL reset: got %b exp %b", obs,
               17'b0_0_0_0_10_00_10_00_0_000_0);
    end
    reset_n  = 1'b1;
    MemReady = 1'b0;
  endtask

  task automatic test_lw();
    logic [16:0] e [5];
    e = '{17'b1_0_0_1_10_00_10_00_0_000_0,
          17'b0_0_0_0_00_01_01_00_0_000_0,
          17'b0_0_0_0_00_10_01_00_0_000_0,
          17'b0_1_0_0_00_00_00_00_0_000_0,
          17'b0_0_0_0_01_00_00_00_1_000_0};
    Op = LW;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); MemReady = 1'b1; #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL lw cyc%0d: got %b exp %b", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_sw_wait();
    logic [16:0] e [8];
    logic        mr [8];
    e = '{17'b0_0_0_0_10_00_10_01_0_000_0,
          17'b1_0_0_1_10_00_10_01_0_000_0,
          17'b0_0_0_0_00_01_01_01_0_000_0,
          17'b0_0_0_0_00_10_01_01_0_000_0,
          17'b0_1_1_0_00_00_00_01_0_000_0,
          17'b0_1_1_0_00_00_00_01_0_000_0,
          17'b0_1_1_0_00_00_00_01_0_000_0,
          17'b0_0_0_0_10_00_10_01_0_000_0};
    mr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    Op = SW;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); MemReady = mr[i]; #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL sw_wait cyc%0d: got %b exp %b", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3 [4];
    logic [3:0] fl [4];
    logic       tk [4];
    logic [16:0] e [3];
    // flags packed {Z,N,V,C}
    f3 = '{3'b100, 3'b100, 3'b110, 3'b001};
    fl = '{4'b0100, 4'b0110, 4'b0000, 4'b1000};
    tk = '{1'b1, 1'b0, 1'b1, 1'b0};
    Op = BR;
    for (int c = 0; c < 4; c++) begin
      funct3 = f3[c];
      {Zero, Negative, Overflow, Carry} = fl[c];
      e = '{17'b1_0_0_1_10_00_10_10_0_000_0,
            17'b0_0_0_0_00_01_01_10_0_000_0,
            {tk[c], 16'b0_0_0_00_10_00_10_0_001_0}};
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); MemReady = 1'b1; #1;
        checks++;
        if (obs !== e[i]) begin
          errors++;
          $display("FAIL branch%0d cyc%0d: got %b exp %b",
                   c, i, obs, e[i]);
        end
      end
    end
    {Zero, Negative, Overflow, Carry} = 4'b0000;
  endtask

  task automatic test_alu_decode();
    logic [6:0] op [3];
    logic [2:0] f3 [3];
    logic [16:0] ex [3];
    logic [16:0] e [4];
    op = '{RT, IT, IT};
    f3 = '{3'b000, 3'b000, 3'b110};
    ex = '{17'b0_0_0_0_00_10_00_00_0_001_0,
           17'b0_0_0_0_00_10_01_00_0_000_0,
           17'b0_0_0_0_00_10_01_00_0_011_0};
    funct7b5 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      Op = op[c];
      funct3 = f3[c];
      e = '{17'b1_0_0_1_10_00_10_00_0_000_0,
            17'b0_0_0_0_00_01_01_00_0_000_0,
            ex[c],
            17'b0_0_0_0_00_00_00_00_1_000_0};
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); MemReady = 1'b1; #1;
        checks++;
        if (obs !== e[i]) begin
          errors++;
          $display("FAIL alu%0d cyc%0d: got %b exp %b",
                   c, i, obs, e[i]);
        end
      end
    end
    funct7b5 = 1'b0;
    funct3 = 3'b000;
  endtask

  task automatic test_jal();
    logic [16:0] e [4];
    e = '{17'b1_0_0_1_10_00_10_11_0_000_0,
          17'b0_0_0_0_00_01_01_11_0_000_0,
          17'b1_0_0_0_00_01_10_11_0_000_0,
          17'b0_0_0_0_00_00_00_11_1_000_0};
    Op = JL;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); MemReady = 1'b1; #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL jal cyc%0d: got %b exp %b", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_illegal_funct();
    logic [16:0] e [6];
    e = '{17'b1_0_0_1_10_00_10_00_0_000_0,
          17'b0_0_0_0_00_01_01_00_0_000_0,
          17'b0_0_0_0_00_10_00_00_0_000_0,
          17'b0_0_0_0_00_00_00_00_0_000_1,
          17'b0_0_0_0_00_00_00_00_0_000_1,
          17'b0_0_0_0_00_00_00_00_0_000_1};
    Op = RT;
    funct3 = 3'b001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); MemReady = 1'b1; #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL ill_funct cyc%0d: got %b exp %b",
                 i, obs, e[i]);
      end
    end
    funct3 = 3'b000;
  endtask

  task automatic test_trap_ext0();
    logic [16:0] e [13];
    for (int i = 3; i < 13; i++)
      e[i] = 17'b0_0_0_0_00_00_00_10_0_000_1;
    e[0] = 17'b1_0_0_1_10_00_10_10_0_000_0;
    e[1] = 17'b0_0_0_0_00_01_01_10_0_000_0;
    e[2] = 17'b0_0_0_0_00_10_00_10_0_001_0;
    Op = BR;
    funct3 = 3'b001;
    Zero = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk); MemReady = 1'b1; #1;
      checks++;
      if (obs_b !== e[i]) begin
        errors++;
        $display("FAIL trap_ext0 cyc%0d: got %b exp %b",
                 i, obs_b, e[i]);
      end
      if (i == 3) Zero = 1'b1;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs_b !== 17'b0_0_0_0_10_00_10_10_0_000_0) begin
      errors++;
      $display("FAIL trap_reset: got %b exp %b", obs_b,
               17'b0_0_0_0_10_00_10_10_0_000_0);
    end
    @(negedge clk); #1;
    reset_n  = 1'b1;
    MemReady = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (obs_b !== 17'b0_0_0_0_10_00_10_10_0_000_0) begin
      errors++;
      $display("FAIL trap_release: got %b exp %b", obs_b,
               17'b0_0_0_0_10_00_10_10_0_000_0);
    end
    Zero = 1'b0;
    funct3 = 3'b000;
  endtask

  task automatic test_reset_memwb();
    logic [16:0] e [5];
    e = '{17'b1_0_0_1_10_00_10_00_0_000_0,
          17'b0_0_0_0_00_01_01_00_0_000_0,
          17'b0_0_0_0_00_10_01_00_0_000_0,
          17'b0_1_0_0_00_00_00_00_0_000_0,
          17'b0_0_0_0_01_00_00_00_1_000_0};
    Op = LW;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); MemReady = 1'b1; #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL rst_memwb cyc%0d: got %b exp %b",
                 i, obs, e[i]);
      end
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== 17'b0_0_0_0_10_00_10_00_0_000_0) begin
      errors++;
      $display("FAIL rst_async: got %b exp %b", obs,
               17'b0_0_0_0_10_00_10_00_0_000_0);
    end
    @(negedge clk); #1;
    reset_n  = 1'b1;
    MemReady = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (obs !== 17'b0_0_0_0_10_00_10_00_0_000_0) begin
      errors++;
      $display("FAIL rst_stall: got %b exp %b", obs,
               17'b0_0_0_0_10_00_10_00_0_000_0);
    end
    MemReady = 1'b1;
    #1;
    checks++;
    if (obs !== 17'b1_0_0_1_10_00_10_00_0_000_0) begin
      errors++;
      $display("FAIL rst_fetch: got %b exp %b", obs,
               17'b1_0_0_1_10_00_10_00_0_000_0);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_branch();
    test_alu_decode();
    test_jal();
    test_illegal_funct();
    test_reset();
    test_trap_ext0();
    test_reset_memwb();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised control unit for the multicycle RV32I datapath. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback over 3–5+ cycles. It drives all datapath enables and muxes, and waits on a memory-ready handshake. Compared with the single-cycle decoder it adds:
- optional full conditional-branch support (BNE/BLT/BGE/BLTU/BGEU) using ALU flags;
- memory wait states;
- an illegal-instruction trap.

## Interface
Parameters:
- EXT_BRANCH, 1, 1: all six B-type conditions; 0: BEQ only, other B-type funct3 trap
- MEM_HANDSHAKE, 1, 1: MemReady honoured; 0: MemReady treated as constant 1

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- Op  in  7  instruction opcode (registered IR)
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- Zero, Negative, Overflow, Carry  in  1 each  ALU flags of current ALU result; Carry = carry-out of A−B
- MemReady  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR/OldPC enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rd1
- ALUSrcB  out  2  00 rd2, 01 ImmExt, 10 constant 4
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- RegWrite  out  1  register-file write enable
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- Illegal  out  1  sticky trap indicator

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, TRAP.

Transitions:
- FETCH → DECODE when MemReady, else hold.
- DECODE dispatches on Op:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - otherwise → TRAP
- MEMADR → MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD → MEMWB when MemReady, else hold. MEMWB → FETCH.
- MEMWRITE → FETCH when MemReady, else hold.
- EXECUTER, EXECUTEI, JAL → ALUWB. ALUWB → FETCH.
- BRANCH → FETCH, or → TRAP on an unsupported funct3.
- TRAP: absorbing; exit only via reset.

Per-state outputs (unlisted signals = 0 / 00):
- FETCH: AdrSrc 0; ALUSrcB 10; ResultSrc 10; add. IRWrite and PCWrite both = MemReady.
- DECODE: ALUSrcA 01; ALUSrcB 01; add (branch target → ALUOut).
- MEMADR: ALUSrcA 10; ALUSrcB 01; add.
- MEMREAD: AdrSrc 1.
- MEMWB: ResultSrc 01; RegWrite.
- MEMWRITE: AdrSrc 1; MemWrite = 1 every cycle of the state (write-hold until MemReady).
- EXECUTER: ALUSrcA 10; ALUSrcB 00; R-type decode.
- EXECUTEI: ALUSrcA 10; ALUSrcB 01; I-type decode.
- ALUWB: ResultSrc 00; RegWrite.
- BRANCH: ALUSrcA 10; ALUSrcB 00; sub; ResultSrc 00; PCWrite = taken.
- JAL: ALUSrcA 01; ALUSrcB 10; add; ResultSrc 00; PCWrite.
- TRAP: all strobes 0; Illegal 1.

ALU decode:
- R-type: funct7b5 & funct3 = 000 → sub.
- I-type: funct3 000 → add, always (no subi).
- funct3 010 → slt; 110 → or; 111 → and.
- Any other funct3 on R/I-type → TRAP from EXECUTER/EXECUTEI; no RegWrite.

Branch taken, by funct3:
- 000: Zero
- 001: !Zero
- 100: Negative ^ Overflow
- 101: !(Negative ^ Overflow)
- 110: !Carry
- 111: Carry

ImmSrc is combinational from Op: lw/I-type 00, sw 01, B 10, jal 11; others 00.

## Timing
- Next-state and state register: single always_ff on clk posedge with async clear on negedge reset_n. Reset state FETCH. Illegal resets to 0.
- While reset_n = 0: PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. Mux selects show FETCH values.
- Outputs are combinational from state, with Mealy terms only on MemReady (FETCH) and flags (BRANCH).
- Cycles per instruction with MemReady held at 1:
  - lw 5
  - sw 4
  - R-type 4
  - I-type 4
  - jal 4
  - branch 3
- Each MemReady = 0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. No outputs change during the stall.
- Reset asserted mid-instruction aborts it immediately. No partial write is committed after the asynchronous edge.

## Structure
- Package riscv_mc_pkg holds:
  - state enum mc_state_t;
  - opcode localparams;
  - ALUControl, ResultSrc, ALUSrcA/B and ImmSrc encodings.
- Sub-module mc_alu_ctrl_dec: combinational ALU decode plus branch-condition evaluation. It returns ALUControl, taken and funct_illegal.

## Test plan
- Reset, then lw with MemReady always 1 → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite high only in cycle 5, with ResultSrc 01.
- sw with MemReady low for 2 cycles in MEMWRITE → MemWrite high for 3 cycles; FETCH on the 4th.
- EXT_BRANCH=1, funct3 = 100, Negative=1, Overflow=0 → PCWrite=1 in BRANCH. Repeat with Overflow=1 → PCWrite=0.
- EXT_BRANCH=0, funct3 = 001 → TRAP; Illegal sticks high; strobes stay 0 for 10 cycles; reset_n low returns to FETCH.
- Op = 0110011, funct3 = 000, funct7b5 = 1 → ALUControl 001 in EXECUTER. With Op = 0010011, same funct3 and funct7b5 → 000.
- reset_n pulsed low during MEMWB → RegWrite drops asynchronously; FETCH after release.
